// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, reset/NOP defaults and FSM state codes.
package fetch_stage_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_WORD     = 32'h0000_0000;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: one read request at a time over valid/ready, response one or more cycles later.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic               inst_req_valid;
   logic               inst_req_ready;
   logic [ADDR_W-1:0]  inst_addr;
   logic               inst_rsp_valid;
   logic [INSTR_W-1:0] inst_rdata;

   modport master (
      output inst_req_valid, inst_addr,
      input  inst_req_ready, inst_rsp_valid, inst_rdata
   );

   modport slave (
      input  inst_req_valid, inst_addr,
      output inst_req_ready, inst_rsp_valid, inst_rdata
   );

endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: load captures a fetched word, flush inserts a bubble, neither holds.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               flush_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_o,
   output logic [ADDR_W-1:0]  pc_plus4_o
);

   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  pc_plus4_q;

   // Flush keeps the pc fields; only valid/instr describe a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
      end else if (flush_i) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
      end else if (load_i) begin
         valid_q    <= 1'b1;
         instr_q    <= instr_i;
         pc_q       <= pc_i;
         pc_plus4_q <= pc_i + ADDR_W'(4);
      end
   end

   assign valid_o    = valid_q;
   assign instr_o    = instr_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem read FSM, redirect/kill and stall buffering.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
   input  logic               clk,
   input  logic               rst,
   fetch_stage_if.master      imem,
   input  logic               id_stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [ADDR_W-1:0]  if_id_pc_plus4,
   output logic               if_adel
);

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               kill_q, kill_d;
   logic               adel_q, adel_d;
   logic [INSTR_W-1:0] buf_q, buf_d;
   logic               redirect, accept, load, flush;
   logic [INSTR_W-1:0] load_word;

   assign redirect            = redirect_valid && !id_stall;
   assign imem.inst_req_valid = !rst && (state_q == S_REQ) && !adel_q;
   assign imem.inst_addr      = pc_q;
   assign accept              = imem.inst_req_valid && imem.inst_req_ready;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      kill_d    = kill_q;
      adel_d    = adel_q;
      buf_d     = buf_q;
      load      = 1'b0;
      load_word = buf_q;
      case (state_q)
         S_REQ: begin
            if (adel_q)      state_d = S_ERR;
            else if (accept) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem.inst_rsp_valid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else if (id_stall) begin
                  buf_d   = imem.inst_rdata;
                  state_d = S_HOLD;
               end else begin
                  load      = 1'b1;
                  load_word = imem.inst_rdata;
                  pc_d      = pc_q + ADDR_W'(4);
                  state_d   = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (!id_stall) begin
               load    = 1'b1;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_REQ;
            end
         end
         default: ;
      endcase
      if (redirect) begin
         pc_d   = redirect_pc;
         adel_d = |redirect_pc[1:0];
         load   = 1'b0;
         case (state_q)
            S_REQ: begin
               kill_d  = accept;
               state_d = accept ? S_WAIT : S_REQ;
            end
            // A response landing with the redirect is the wrong-path word itself,
            // so drop it now rather than arm kill for a response that never comes.
            S_WAIT: begin
               kill_d  = !imem.inst_rsp_valid;
               state_d = imem.inst_rsp_valid ? S_REQ : S_WAIT;
            end
            default: begin
               kill_d  = 1'b0;
               state_d = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         adel_q  <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         adel_q  <= adel_d;
         buf_q   <= buf_d;
      end
   end

   assign flush   = !id_stall && !load;
   assign if_adel = adel_q;

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .flush_i    (flush),
      .instr_i    (load_word),
      .pc_i       (pc_q),
      .valid_o    (if_id_valid),
      .instr_o    (if_id_instr),
      .pc_o       (if_id_pc),
      .pc_plus4_o (if_id_pc_plus4)
   );

endmodule
